// File: rtl/me_search_ctrl.sv
// Full-search motion-estimation sequencer: drives the PE array strobes,
// tracks the minimum SAD in scan order and reports the winning vector.
module me_search_ctrl #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int SAD_LAT    = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(MACRO_DIM)-1:0]  cpr_addr,
    output logic [$clog2(SEARCH_DIM)-1:0] spr_row_addr,
    output logic [$clog2(SEARCH_DIM)-1:0] spr_col_addr,
    output logic                          en_cpr,
    output logic                          en_spr,
    input  logic [15:0]                   sad_in,
    output logic [6:0]                    mv_x,
    output logic [6:0]                    mv_y,
    output logic [15:0]                   min_sad
);

    localparam int CW   = $clog2(MACRO_DIM);
    localparam int SW   = $clog2(SEARCH_DIM);
    localparam int NPOS = SEARCH_DIM - MACRO_DIM + 1;
    localparam int OFF  = (SEARCH_DIM - MACRO_DIM) / 2;

    localparam logic [SW-1:0] ROW_LAST = SW'(SEARCH_DIM - 1);
    localparam logic [SW-1:0] COL_LAST = SW'(NPOS - 1);
    localparam logic [SW-1:0] FILL     = SW'(MACRO_DIM - 1);
    localparam logic [7:0]    CPR_LAST = 8'(MACRO_DIM - 1);
    localparam logic [7:0]    FIN_CNT  = 8'(SAD_LAT);
    localparam logic [7:0]    END_CNT  = 8'(SAD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_CPR,
        SEARCH,
        DRAIN
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic [SW-1:0] row, row_nxt;
    logic [SW-1:0] col, col_nxt;
    logic          issue_cpr, issue_spr;
    logic          init_best, fin;

    logic [SAD_LAT:0] tag_v;
    logic [SW-1:0]    tag_x [SAD_LAT+1];
    logic [SW-1:0]    tag_y [SAD_LAT+1];

    logic [15:0]   best, best_nxt;
    logic [SW-1:0] bx, by, bx_nxt, by_nxt;
    logic          hit;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        row_nxt   = row;
        col_nxt   = col;
        issue_cpr = 1'b0;
        issue_spr = 1'b0;
        init_best = 1'b0;
        fin       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD_CPR;
                    cnt_nxt   = '0;
                    init_best = 1'b1;
                end
            end
            LOAD_CPR: begin
                issue_cpr = 1'b1;
                cnt_nxt   = cnt + 8'd1;
                if (cnt == CPR_LAST) begin
                    state_nxt = SEARCH;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end
            end
            SEARCH: begin
                issue_spr = 1'b1;
                if (row == ROW_LAST) begin
                    row_nxt = '0;
                    col_nxt = col + SW'(1);
                    if (col == COL_LAST) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = '0;
                    end
                end else begin
                    row_nxt = row + SW'(1);
                end
            end
            DRAIN: begin
                cnt_nxt = cnt + 8'd1;
                fin     = (cnt == FIN_CNT);
                if (cnt == END_CNT)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Running minimum including the SAD arriving this cycle, so the
    // final candidate is folded into the result latched with done.
    always_comb begin
        hit      = tag_v[SAD_LAT] && (sad_in < best);
        best_nxt = hit ? sad_in : best;
        bx_nxt   = hit ? tag_x[SAD_LAT] : bx;
        by_nxt   = hit ? tag_y[SAD_LAT] : by;
    end

    assign busy         = (state != IDLE);
    assign cpr_addr     = (state == LOAD_CPR) ? cnt[CW-1:0] : '0;
    assign spr_row_addr = (state == SEARCH) ? row : '0;
    assign spr_col_addr = (state == SEARCH) ? col : '0;

    always_ff @(posedge clk) begin
        tag_x[0] <= col;
        tag_y[0] <= row - FILL;
        for (int i = 1; i <= SAD_LAT; i++) begin
            tag_x[i] <= tag_x[i-1];
            tag_y[i] <= tag_y[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            row     <= '0;
            col     <= '0;
            en_cpr  <= 1'b0;
            en_spr  <= 1'b0;
            tag_v   <= '0;
            best    <= '0;
            bx      <= '0;
            by      <= '0;
            done    <= 1'b0;
            min_sad <= '0;
            mv_x    <= '0;
            mv_y    <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            row    <= row_nxt;
            col    <= col_nxt;
            en_cpr <= issue_cpr;
            en_spr <= issue_spr;
            tag_v  <= {tag_v[SAD_LAT-1:0], issue_spr && (row >= FILL)};
            done   <= fin;
            if (init_best) begin
                best <= 16'hFFFF;
                bx   <= '0;
                by   <= '0;
            end else begin
                best <= best_nxt;
                bx   <= bx_nxt;
                by   <= by_nxt;
            end
            if (fin) begin
                min_sad <= best_nxt;
                mv_x    <= 7'(bx_nxt) - 7'(OFF);
                mv_y    <= 7'(by_nxt) - 7'(OFF);
            end
        end
    end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl: emulates the SAD tree from a cost table and
// scores every output cycle and every reported result.
module tb_me_search_ctrl;

    localparam int M  = 16;
    localparam int S  = 48;
    localparam int L  = 6;
    localparam int NP = S - M + 1;
    localparam int OF = (S - M) / 2;
    localparam int FIRST_TAG = 2 * M + 1 + L;
    localparam int DONE_R    = M + 1 + NP * S + 1 + L;

    typedef struct {
        int ms;
        int mx;
        int my;
    } res_t;

    logic       clk = 0;
    logic       rst_n;
    logic       start;
    logic       busy, done;
    logic [3:0] cpr_addr;
    logic [5:0] spr_row_addr, spr_col_addr;
    logic       en_cpr, en_spr;
    logic [15:0] sad_in;
    logic [6:0] mv_x, mv_y;
    logic [15:0] min_sad;

    me_search_ctrl #(.MACRO_DIM(M), .SEARCH_DIM(S), .SAD_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cpr_addr(cpr_addr), .spr_row_addr(spr_row_addr),
        .spr_col_addr(spr_col_addr), .en_cpr(en_cpr), .en_spr(en_spr),
        .sad_in(sad_in), .mv_x(mv_x), .mv_y(mv_y), .min_sad(min_sad)
    );

    always #5 clk = ~clk;

    int   cost [NP][NP];
    res_t exp_q [$];
    res_t hold;
    int   cyc = 0;
    int   t0 = 0;
    bit   act = 0;
    bit   chk_on = 0;
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string n, input int a, input int e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     n, a, e, cyc);
        end
    endtask

    function automatic res_t model();
        res_t r;
        int b = 65535;
        int bx = 0;
        int by = 0;
        for (int x = 0; x < NP; x++)
            for (int y = 0; y < NP; y++)
                if (cost[x][y] < b) begin
                    b = cost[x][y];
                    bx = x;
                    by = y;
                end
        r.ms = b;
        r.mx = bx - OF;
        r.my = by - OF;
        return r;
    endfunction

    task automatic fill_const(input int v);
        for (int x = 0; x < NP; x++)
            for (int y = 0; y < NP; y++)
                cost[x][y] = v;
    endtask

    task automatic fill_rand();
        int v;
        for (int x = 0; x < NP; x++)
            for (int y = 0; y < NP; y++)
                cost[x][y] = $urandom_range(200, 65535);
        v = $urandom_range(0, 150);
        for (int i = 0; i < 3; i++)
            cost[$urandom_range(0, NP-1)][$urandom_range(0, NP-1)] = v;
    endtask

    // SAD tree emulation: candidate (x,y) lands FIRST_TAG+S*x+y after start.
    task automatic drive_sad();
        int rel, k, x, y;
        sad_in = 16'($urandom);
        if (act) begin
            rel = cyc - t0;
            if (rel >= FIRST_TAG) begin
                k = rel - FIRST_TAG;
                x = k / S;
                y = k % S;
                if (x < NP && y < NP)
                    sad_in = 16'(cost[x][y]);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        cyc++;
        #1;
        drive_sad();
    endtask

    task automatic start_run();
        start = 1'b1;
        t0 = cyc;
        act = 1'b1;
        exp_q.push_back(model());
    endtask

    task automatic wait_rel(input int r);
        while (cyc - t0 < r)
            next_cycle();
    endtask

    always @(negedge clk) begin : mon
        int rel, k;
        int e_cpr, e_row, e_col;
        bit e_busy, e_encpr, e_enspr, e_done;
        res_t r;
        if (chk_on) begin
            rel = cyc - t0;
            e_busy  = act && rel >= 1 && rel <= DONE_R;
            e_cpr   = (act && rel >= 1 && rel <= M) ? rel - 1 : 0;
            e_encpr = act && rel >= 2 && rel <= M + 1;
            e_enspr = act && rel >= M + 2 && rel <= M + 1 + NP * S;
            e_done  = act && rel == DONE_R;
            e_row = 0;
            e_col = 0;
            if (act && rel >= M + 1 && rel <= M + NP * S) begin
                k = rel - M - 1;
                e_row = k % S;
                e_col = k / S;
            end
            check("busy", int'(busy), int'(e_busy));
            check("done", int'(done), int'(e_done));
            check("cpr_addr", int'(cpr_addr), e_cpr);
            check("en_cpr", int'(en_cpr), int'(e_encpr));
            check("en_spr", int'(en_spr), int'(e_enspr));
            check("spr_row_addr", int'(spr_row_addr), e_row);
            check("spr_col_addr", int'(spr_col_addr), e_col);
            if (done) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_done: got done with no run pending at cycle %0d", cyc);
                end else begin
                    r = exp_q.pop_front();
                    hold = r;
                end
            end
            check("min_sad", int'(min_sad), hold.ms);
            check("mv_x", int'($signed(mv_x)), hold.mx);
            check("mv_y", int'($signed(mv_y)), hold.my);
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sad_in = '0;
        hold = '{0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom);
            next_cycle();
            chk_on = 1'b1;
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) next_cycle();

        fill_const(1000);
        cost[20][5] = 7;
        start_run();
        next_cycle();
        start = 1'b0;
        wait_rel(500);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_rel(DONE_R + 4);

        fill_const(500);
        cost[3][9] = 300;
        cost[30][2] = 300;
        start_run();
        next_cycle();
        start = 1'b0;
        wait_rel(DONE_R + 4);

        fill_rand();
        start_run();
        next_cycle();
        start = 1'b0;
        wait_rel(800);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        act = 1'b0;
        exp_q.delete();
        hold = '{0, 0, 0};
        repeat (3) next_cycle();

        fill_rand();
        start_run();
        next_cycle();
        start = 1'b0;
        wait_rel(DONE_R + 4);

        fill_rand();
        start_run();
        next_cycle();
        wait_rel(DONE_R + 1);
        fill_rand();
        start_run();
        next_cycle();
        start = 1'b0;
        wait_rel(DONE_R + 4);

        check("runs_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
